axi_lite_master_if: RTL and testbench

Single-outstanding AXI master front end that turns a simple four-phase command handshake (request/ack) into single-beat AXI write (AW/W/B) or read (AR/R) transactions. It is the initiator counterpart of the slave interface on the same bus. It sits between a local controller (CPU bridge, test sequencer) and the interconnect, driving the slave's AXI channels directly.

---
 rtl/axi_lite_master_if_if.sv | 73 +++++++
 rtl/axi_lite_master_if.sv | 210 +++++++++++++++++++++
 tb/tb_axi_lite_master_if.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_master_if_if.sv
// rtl/axi_lite_master_if_if.sv - command-side and AXI channel bundle for axi_lite_master_if
interface axi_lite_master_if_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Local command handshake
  logic                  CMD_REQ;
  logic                  CMD_WR;
  logic [ADDR_WIDTH-1:0] CMD_ADDR;
  logic [DATA_WIDTH-1:0] CMD_WDATA;
  logic                  CMD_ACK;
  logic [DATA_WIDTH-1:0] CMD_RDATA;
  logic [1:0]            CMD_RESP;
  logic                  CMD_ERROR;

  // Write address / data / response channels
  logic [ADDR_WIDTH-1:0] AW_ADDR;
  logic [7:0]            AW_LEN;
  logic [2:0]            AW_SIZE;
  logic [1:0]            AW_BURST;
  logic                  AW_VALID;
  logic                  AW_READY;
  logic [DATA_WIDTH-1:0] W_DATA;
  logic                  W_LAST;
  logic                  W_VALID;
  logic                  W_READY;
  logic [1:0]            B_RESP;
  logic                  B_VALID;
  logic                  B_READY;

  // Read address / data channels
  logic [ADDR_WIDTH-1:0] AR_ADDR;
  logic [7:0]            AR_LEN;
  logic [2:0]            AR_SIZE;
  logic [1:0]            AR_BURST;
  logic                  AR_VALID;
  logic                  AR_READY;
  logic [DATA_WIDTH-1:0] R_DATA;
  logic [1:0]            R_RESP;
  logic                  R_LAST;
  logic                  R_VALID;
  logic                  R_READY;

  modport master (
    input  CMD_REQ, CMD_WR, CMD_ADDR, CMD_WDATA,
    output CMD_ACK, CMD_RDATA, CMD_RESP, CMD_ERROR,
    output AW_ADDR, AW_LEN, AW_SIZE, AW_BURST, AW_VALID,
    input  AW_READY,
    output W_DATA, W_LAST, W_VALID,
    input  W_READY,
    input  B_RESP, B_VALID,
    output B_READY,
    output AR_ADDR, AR_LEN, AR_SIZE, AR_BURST, AR_VALID,
    input  AR_READY,
    input  R_DATA, R_RESP, R_LAST, R_VALID,
    output R_READY
  );

  modport slave (
    output CMD_REQ, CMD_WR, CMD_ADDR, CMD_WDATA,
    input  CMD_ACK, CMD_RDATA, CMD_RESP, CMD_ERROR,
    input  AW_ADDR, AW_LEN, AW_SIZE, AW_BURST, AW_VALID,
    output AW_READY,
    input  W_DATA, W_LAST, W_VALID,
    output W_READY,
    output B_RESP, B_VALID,
    input  B_READY,
    input  AR_ADDR, AR_LEN, AR_SIZE, AR_BURST, AR_VALID,
    output AR_READY,
    output R_DATA, R_RESP, R_LAST, R_VALID,
    input  R_READY
  );
endinterface

// File: rtl/axi_lite_master_if.sv
// rtl/axi_lite_master_if.sv - single-outstanding AXI master driven by a four-phase req/ack command port (optional watchdog: AXI_M_TIMEOUT_EN)
module axi_lite_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
`ifdef AXI_M_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input logic                  ACLK,
  input logic                  ARESETn,
  axi_lite_master_if_if.master bus
);

  localparam logic [2:0] AX_SIZE = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic [5:0] {
    IDLE    = 6'b000001,
    WR_XFER = 6'b000010,
    WR_RESP = 6'b000100,
    RD_ADDR = 6'b001000,
    RD_DATA = 6'b010000,
    DONE    = 6'b100000
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;
  logic                  aw_valid_q, aw_valid_d;
  logic                  w_valid_q, w_valid_d;
  logic                  b_ready_q, b_ready_d;
  logic                  ar_valid_q, ar_valid_d;
  logic                  r_ready_q, r_ready_d;
  logic                  ack_q, ack_d;
  logic                  timeout;
  logic                  abort;
  logic                  unused_rlast;

  // Single-beat transfers only, so R_LAST carries no information.
  assign unused_rlast = bus.R_LAST;

`ifdef AXI_M_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;

  // Watchdog: restarts on every state change, counts while waiting on the slave
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (state_q != IDLE && state_q != DONE) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // State and every bus-facing output register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      resp_q     <= 2'b00;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      resp_q     <= resp_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_ready_q  <= b_ready_d;
      ar_valid_q <= ar_valid_d;
      r_ready_q  <= r_ready_d;
      ack_q      <= ack_d;
    end
  end

  // Next state plus next values of the registered outputs
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    resp_d     = resp_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    b_ready_d  = b_ready_q;
    ar_valid_d = ar_valid_q;
    r_ready_d  = r_ready_q;
    ack_d      = 1'b0;
    abort      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.CMD_REQ) begin
          addr_d  = bus.CMD_ADDR;
          wdata_d = bus.CMD_WDATA;
          if (bus.CMD_WR) begin
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            state_d    = WR_XFER;
          end else begin
            ar_valid_d = 1'b1;
            state_d    = RD_ADDR;
          end
        end
      end
      WR_XFER: begin
        // AW and W retire independently; move on once neither is pending.
        aw_valid_d = aw_valid_q & ~bus.AW_READY;
        w_valid_d  = w_valid_q & ~bus.W_READY;
        if (!aw_valid_d && !w_valid_d) begin
          b_ready_d = 1'b1;
          state_d   = WR_RESP;
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      WR_RESP: begin
        if (bus.B_VALID) begin
          b_ready_d = 1'b0;
          resp_d    = bus.B_RESP;
          ack_d     = 1'b1;
          state_d   = DONE;
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      RD_ADDR: begin
        if (bus.AR_READY) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = RD_DATA;
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      RD_DATA: begin
        if (bus.R_VALID) begin
          r_ready_d = 1'b0;
          rdata_d   = bus.R_DATA;
          resp_d    = bus.R_RESP;
          ack_d     = 1'b1;
          state_d   = DONE;
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      DONE: begin
        // Four-phase: a request still held after the ack must not reissue.
        if (!bus.CMD_REQ) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Watchdog expiry abandons the bus and reports a DECERR-style completion.
    if (abort) begin
      aw_valid_d = 1'b0;
      w_valid_d  = 1'b0;
      b_ready_d  = 1'b0;
      ar_valid_d = 1'b0;
      r_ready_d  = 1'b0;
      resp_d     = 2'b11;
      ack_d      = 1'b1;
      state_d    = DONE;
    end
  end

  assign bus.CMD_ACK   = ack_q;
  assign bus.CMD_RDATA = rdata_q;
  assign bus.CMD_RESP  = resp_q;
  assign bus.CMD_ERROR = resp_q[1];

  assign bus.AW_ADDR  = addr_q;
  assign bus.AW_LEN   = 8'd0;
  assign bus.AW_SIZE  = AX_SIZE;
  assign bus.AW_BURST = 2'b01;
  assign bus.AW_VALID = aw_valid_q;
  assign bus.W_DATA   = wdata_q;
  assign bus.W_LAST   = w_valid_q;
  assign bus.W_VALID  = w_valid_q;
  assign bus.B_READY  = b_ready_q;

  assign bus.AR_ADDR  = addr_q;
  assign bus.AR_LEN   = 8'd0;
  assign bus.AR_SIZE  = AX_SIZE;
  assign bus.AR_BURST = 2'b01;
  assign bus.AR_VALID = ar_valid_q;
  assign bus.R_READY  = r_ready_q;

endmodule

// File: tb/tb_axi_lite_master_if.sv
// tb/tb_axi_lite_master_if.sv - directed scoreboard bench for axi_lite_master_if
module tb_axi_lite_master_if;

  logic clk;
  logic rst_n;

  axi_lite_master_if_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_lite_master_if #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
`ifdef AXI_M_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .ACLK    (clk),
    .ARESETn (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  // Slave configuration
  int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  bit          ar_never = 0;
  logic [1:0]  b_resp = 2'b00, r_resp = 2'b00;
  logic [31:0] r_data = '0;

  // Monitor observations
  int          aw_hs = 0, w_hs = 0, ar_hs = 0;
  int          aw_vcyc = 0, w_vcyc = 0, ar_vcyc = 0;
  int          viol = 0;
  logic [31:0] aw_seen = '0, w_seen = '0, ar_seen = '0;
  logic [31:0] last_rd = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Responding slave and bus monitor, acting just after each falling edge
  initial begin
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    bus.AW_READY = 0; bus.W_READY = 0; bus.AR_READY = 0;
    bus.B_VALID = 0; bus.B_RESP = 0;
    bus.R_VALID = 0; bus.R_RESP = 0; bus.R_DATA = '0; bus.R_LAST = 0;
    forever begin
      @(negedge clk); #1;
      if (!bus.AW_VALID) begin bus.AW_READY = 0; aw_cnt = aw_delay; end
      else if (aw_cnt == 0) bus.AW_READY = 1;
      else begin bus.AW_READY = 0; aw_cnt--; end
      if (!bus.W_VALID) begin bus.W_READY = 0; w_cnt = w_delay; end
      else if (w_cnt == 0) bus.W_READY = 1;
      else begin bus.W_READY = 0; w_cnt--; end
      if (!bus.AR_VALID || ar_never) begin bus.AR_READY = 0; ar_cnt = ar_delay; end
      else if (ar_cnt == 0) bus.AR_READY = 1;
      else begin bus.AR_READY = 0; ar_cnt--; end
      if (!bus.B_READY) begin bus.B_VALID = 0; b_cnt = b_delay; end
      else if (b_cnt == 0) begin bus.B_VALID = 1; bus.B_RESP = b_resp; end
      else begin bus.B_VALID = 0; b_cnt--; end
      if (!bus.R_READY) begin bus.R_VALID = 0; bus.R_LAST = 0; r_cnt = r_delay; end
      else if (r_cnt == 0) begin
        bus.R_VALID = 1; bus.R_LAST = 1; bus.R_DATA = r_data; bus.R_RESP = r_resp;
      end
      else begin bus.R_VALID = 0; r_cnt--; end

      if (bus.AW_VALID) aw_vcyc++;
      if (bus.W_VALID) w_vcyc++;
      if (bus.AR_VALID) ar_vcyc++;
      if (bus.AW_VALID && bus.AW_READY) begin aw_hs++; aw_seen = bus.AW_ADDR; end
      if (bus.W_VALID && bus.W_READY) begin w_hs++; w_seen = bus.W_DATA; end
      if (bus.AR_VALID && bus.AR_READY) begin ar_hs++; ar_seen = bus.AR_ADDR; end
      if (bus.W_LAST !== bus.W_VALID) viol++;
      if (bus.B_READY && (bus.AW_VALID || bus.W_VALID)) viol++;
    end
  end

  task automatic clear_mon();
    aw_hs = 0; w_hs = 0; ar_hs = 0;
    aw_vcyc = 0; w_vcyc = 0; ar_vcyc = 0;
  endtask

  task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] resp, input logic [31:0] rd,
                        input int lat_exp, input int hold);
    exp_t e;
    int   lat, acks, v0;
    bit   got;
    e.wr = wr; e.addr = addr; e.wdata = wdata; e.resp = resp;
    e.rdata = wr ? last_rd : rd;
    sb.push_back(e);
    b_resp = resp; r_resp = resp; r_data = rd;
    @(negedge clk);
    clear_mon();
    bus.CMD_REQ = 1; bus.CMD_WR = wr; bus.CMD_ADDR = addr; bus.CMD_WDATA = wdata;
    lat = 0; got = 0;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (bus.CMD_ACK) got = 1;
    end
    check("ack_seen", 64'(got), 64'd1);
    e = sb.pop_front();
    check("latency", 64'(lat), 64'(lat_exp));
    check("cmd_resp", 64'(bus.CMD_RESP), 64'(e.resp));
    check("cmd_error", 64'(bus.CMD_ERROR), 64'(e.resp[1]));
    check("cmd_rdata", 64'(bus.CMD_RDATA), 64'(e.rdata));
    if (e.wr) begin
      check("aw_hs", 64'(aw_hs), 64'd1);
      check("w_hs", 64'(w_hs), 64'd1);
      check("aw_addr", 64'(aw_seen), 64'(e.addr));
      check("w_data", 64'(w_seen), 64'(e.wdata));
    end else begin
      check("ar_hs", 64'(ar_hs), ar_never ? 64'd0 : 64'd1);
      if (!ar_never) check("ar_addr", 64'(ar_seen), 64'(e.addr));
    end
    last_rd = e.rdata;
    acks = 0;
    v0 = aw_vcyc + w_vcyc + ar_vcyc;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.CMD_ACK) acks++;
    end
    if (hold > 0) begin
      check("held_req_acks", 64'(acks), 64'd0);
      check("held_req_reissue", 64'(aw_vcyc + w_vcyc + ar_vcyc - v0), 64'd0);
    end
    bus.CMD_REQ = 0;
    @(negedge clk);
    check("ack_one_cycle", 64'(bus.CMD_ACK), 64'd0);
  endtask

  initial begin
    int   wait_cyc, acks;
    exp_t e;
    rst_n = 0;
    bus.CMD_REQ = 0; bus.CMD_WR = 0; bus.CMD_ADDR = '0; bus.CMD_WDATA = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", 64'({bus.AW_VALID, bus.W_VALID, bus.B_READY, bus.AR_VALID,
                           bus.R_READY, bus.CMD_ACK, bus.W_LAST, bus.CMD_ERROR}), 64'd0);
    check("rst_data", 64'({bus.AW_ADDR, bus.W_DATA}), 64'd0);
    check("rst_rdata_resp", 64'({bus.CMD_RDATA, bus.CMD_RESP, bus.AR_ADDR}), 64'd0);
    check("aw_const", 64'({bus.AW_LEN, bus.AW_SIZE, bus.AW_BURST}), 64'({8'd0, 3'd2, 2'b01}));
    check("ar_const", 64'({bus.AR_LEN, bus.AR_SIZE, bus.AR_BURST}), 64'({8'd0, 3'd2, 2'b01}));
    rst_n = 1;
    repeat (2) @(negedge clk);

    // Zero-wait write
    do_cmd(1, 32'h10, 32'hA5A5_0001, 2'b00, 32'h0, 3, 0);

    // AW_READY three cycles late, W_READY immediate
    aw_delay = 3;
    do_cmd(1, 32'h14, 32'h1234_5678, 2'b00, 32'h0, 6, 0);
    check("aw_valid_cycles", 64'(aw_vcyc), 64'd4);
    check("w_valid_cycles", 64'(w_vcyc), 64'd1);
    aw_delay = 0;

    // Read with a five-cycle R delay and SLVERR
    r_delay = 5;
    do_cmd(0, 32'h20, 32'h0, 2'b10, 32'hDEAD_BEEF, 8, 0);
    r_delay = 0;

    // Zero-wait read, request held ten cycles after the ack
    do_cmd(0, 32'h24, 32'h0, 2'b00, 32'h0BAD_F00D, 3, 10);

    // Write returning DECERR; read data must stay as last read
    do_cmd(1, 32'h28, 32'hCAFE_0002, 2'b11, 32'h0, 3, 0);

    // Reset while waiting in WR_RESP
    b_delay = 20;
    e.wr = 1; e.addr = 32'h2C; e.wdata = 32'h5555_AAAA; e.resp = 2'b00; e.rdata = last_rd;
    sb.push_back(e);
    @(negedge clk);
    bus.CMD_REQ = 1; bus.CMD_WR = 1; bus.CMD_ADDR = 32'h2C; bus.CMD_WDATA = 32'h5555_AAAA;
    wait_cyc = 0;
    while (!bus.B_READY && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("reach_wr_resp", 64'(bus.B_READY), 64'd1);
    rst_n = 0;
    #1;
    check("midrst_ctrl", 64'({bus.AW_VALID, bus.W_VALID, bus.B_READY, bus.AR_VALID,
                              bus.R_READY, bus.CMD_ACK, bus.W_LAST, bus.CMD_ERROR}), 64'd0);
    check("midrst_data", 64'({bus.AW_ADDR, bus.W_DATA}), 64'd0);
    check("midrst_rdata_resp", 64'({bus.CMD_RDATA, bus.CMD_RESP}), 64'd0);
    void'(sb.pop_front());
    check("sb_drained", 64'(sb.size()), 64'd0);
    last_rd = '0;
    bus.CMD_REQ = 0;
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.CMD_ACK) acks++;
    end
    rst_n = 1;
    b_delay = 0;
    @(negedge clk);
    if (bus.CMD_ACK) acks++;
    check("midrst_no_ack", 64'(acks), 64'd0);

    // Read after reset completes normally
    do_cmd(0, 32'h30, 32'h0, 2'b00, 32'h1357_9BDF, 3, 0);

`ifdef AXI_M_TIMEOUT_EN
    // AR_READY never comes: watchdog aborts after sixteen cycles
    ar_never = 1;
    do_cmd(0, 32'h34, 32'h0, 2'b11, last_rd, 17, 0);
    check("ar_valid_cycles_to", 64'(ar_vcyc), 64'd16);
    check("ar_valid_dropped", 64'(bus.AR_VALID), 64'd0);
    ar_never = 0;
`endif

    check("protocol_viol", 64'(viol), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Overall time guard
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
